// File: rtl/rb_uart_regs_pkg.sv
// rtl/rb_uart_regs_pkg.sv - shared constants and types for the UART register file
package rb_uart_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int INT_W  = 5;

    // Word indices (byte address [11:2]); byte address [1:0] must be zero
    localparam logic [9:0] IDX_CTRL     = 10'd0;
    localparam logic [9:0] IDX_BAUD     = 10'd1;
    localparam logic [9:0] IDX_TXDATA   = 10'd2;
    localparam logic [9:0] IDX_RXDATA   = 10'd3;
    localparam logic [9:0] IDX_STATUS   = 10'd4;
    localparam logic [9:0] IDX_INT_EN   = 10'd5;
    localparam logic [9:0] IDX_INT_STAT = 10'd6;

    // CTRL bit positions
    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_DBITS_LO = 2;
    localparam int CTRL_DBITS_HI = 3;
    localparam int CTRL_STOP2    = 4;
    localparam int CTRL_PAR_EN   = 5;
    localparam int CTRL_PAR_ODD  = 6;

    // Bit 7 of CTRL has no function and always reads back as zero
    localparam logic [7:0] CTRL_MASK = 8'h7F;

    // INT_EN / INT_STAT bit positions
    localparam int INT_RX_AVAIL = 0;
    localparam int INT_TX_EMPTY = 1;
    localparam int INT_RX_OVR   = 2;
    localparam int INT_TX_OVF   = 3;
    localparam int INT_PAR_ERR  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RACK = 2'd1,
        ST_WACK = 2'd2
    } state_t;

endpackage

// File: rtl/rb_uart_regs_if.sv
// rtl/rb_uart_regs_if.sv - generic register bus between a host and the UART register file
interface rb_uart_regs_if;
    import rb_uart_pkg::*;

    logic                rd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   raddr;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                rack;
    logic                wack;
    logic                raddrerr;
    logic                waddrerr;

    modport master (
        output rd_en, wr_en, raddr, waddr, wdata,
        input  rdata, rack, wack, raddrerr, waddrerr
    );

    modport slave (
        input  rd_en, wr_en, raddr, waddr, wdata,
        output rdata, rack, wack, raddrerr, waddrerr
    );

endinterface

// File: rtl/rb_uart_regs_int_ctrl.sv
// rtl/rb_uart_regs_int_ctrl.sv - interrupt status, enable and irq generation
module rb_uart_int_ctrl
    import rb_uart_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             rx_empty,
    input  logic             tx_empty,
    input  logic             rx_ovr,
    input  logic             par_err,
    input  logic             tx_ovf_set,
    input  logic             int_en_we,
    input  logic             w1c_we,
    input  logic [INT_W-1:0] wdata,
    output logic [INT_W-1:0] int_en,
    output logic [INT_W-1:0] int_stat,
    output logic             irq
);

    logic             rx_empty_q;
    logic             tx_empty_q;
    logic [INT_W-1:0] set_vec;
    logic [INT_W-1:0] clr_vec;

    // Collect this cycle's set events and W1C mask
    always_comb begin
        set_vec                = '0;
        set_vec[INT_RX_AVAIL]  = rx_empty_q & ~rx_empty;
        set_vec[INT_TX_EMPTY]  = ~tx_empty_q & tx_empty;
        set_vec[INT_RX_OVR]    = rx_ovr;
        set_vec[INT_TX_OVF]    = tx_ovf_set;
        set_vec[INT_PAR_ERR]   = par_err;
        clr_vec                = w1c_we ? wdata : '0;
    end

    // Status/enable registers; a set arriving with a clear of the same bit wins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_empty_q <= 1'b1;
            tx_empty_q <= 1'b1;
            int_en     <= '0;
            int_stat   <= '0;
            irq        <= 1'b0;
        end else begin
            rx_empty_q <= rx_empty;
            tx_empty_q <= tx_empty;
            if (int_en_we) begin
                int_en <= wdata;
            end
            int_stat   <= (int_stat & ~clr_vec) | set_vec;
            irq        <= |(int_stat & int_en);
        end
    end

endmodule

// File: rtl/rb_uart_regs.sv
// rtl/rb_uart_regs.sv - UART register file: decode, CTRL/BAUD, TX/RX strobes, read mux
module rb_uart_regs
    import rb_uart_pkg::*;
#(
    parameter logic [15:0] BAUD_RST = 16'd54,
    parameter logic [7:0]  CTRL_RST = 8'h0C
) (
    input  logic        apb_pclk,
    input  logic        apb_presetn,
    rb_uart_regs_if.slave bus,
    output logic [7:0]  ctrl,
    output logic [15:0] baud_div,
    output logic        tx_push,
    output logic [7:0]  tx_wdata,
    input  logic        tx_full,
    input  logic        tx_empty,
    input  logic        rx_empty,
    input  logic        rx_full,
    input  logic        tx_busy,
    output logic        rx_pop,
    input  logic [7:0]  rx_data,
    input  logic        rx_ovr,
    input  logic        par_err,
    output logic        irq
);

    state_t             state;
    logic [DATA_W-1:0]  rdata_q;
    logic               rack_q;
    logic               wack_q;
    logic               raddrerr_q;
    logic               waddrerr_q;

    logic               wr_go;
    logic               w_err, w_ctrl, w_baud, w_tx, w_int_en, w_w1c;
    logic               r_err, r_pop;
    logic [DATA_W-1:0]  r_data;
    logic [INT_W-1:0]   int_en;
    logic [INT_W-1:0]   int_stat;
    logic               tx_ovf_set;
    logic               unused_wdata;

    assign bus.rdata    = rdata_q;
    assign bus.rack     = rack_q;
    assign bus.wack     = wack_q;
    assign bus.raddrerr = raddrerr_q;
    assign bus.waddrerr = waddrerr_q;

    assign unused_wdata = ^bus.wdata[DATA_W-1:16];

    // A write is accepted only from IDLE; it takes priority over a read
    assign wr_go      = (state == ST_IDLE) && bus.wr_en;
    assign tx_ovf_set = wr_go && w_tx && tx_full;

    // Write address decode
    always_comb begin
        w_err    = 1'b0;
        w_ctrl   = 1'b0;
        w_baud   = 1'b0;
        w_tx     = 1'b0;
        w_int_en = 1'b0;
        w_w1c    = 1'b0;
        if (bus.waddr[1:0] != 2'b00) begin
            w_err = 1'b1;
        end else begin
            case (bus.waddr[ADDR_W-1:2])
                IDX_CTRL:     w_ctrl   = 1'b1;
                IDX_BAUD:     w_baud   = 1'b1;
                IDX_TXDATA:   w_tx     = 1'b1;
                IDX_INT_EN:   w_int_en = 1'b1;
                IDX_INT_STAT: w_w1c    = 1'b1;
                default:      w_err    = 1'b1;
            endcase
        end
    end

    // Read address decode and data mux; RXDATA pops only when a byte is present
    always_comb begin
        r_err  = 1'b0;
        r_pop  = 1'b0;
        r_data = '0;
        if (bus.raddr[1:0] != 2'b00) begin
            r_err = 1'b1;
        end else begin
            case (bus.raddr[ADDR_W-1:2])
                IDX_CTRL:     r_data = {24'd0, ctrl};
                IDX_BAUD:     r_data = {16'd0, baud_div};
                IDX_RXDATA: begin
                    if (!rx_empty) begin
                        r_data = {24'd0, rx_data};
                        r_pop  = 1'b1;
                    end
                end
                IDX_STATUS:   r_data = {27'd0, tx_busy, rx_full, rx_empty, tx_full, tx_empty};
                IDX_INT_EN:   r_data = {27'd0, int_en};
                IDX_INT_STAT: r_data = {27'd0, int_stat};
                default:      r_err  = 1'b1;
            endcase
        end
    end

    // Transfer FSM; every side effect and registered response is taken on the IDLE->xACK edge
    always_ff @(posedge apb_pclk) begin
        if (!apb_presetn) begin
            state      <= ST_IDLE;
            rdata_q    <= '0;
            rack_q     <= 1'b0;
            wack_q     <= 1'b0;
            raddrerr_q <= 1'b0;
            waddrerr_q <= 1'b0;
            tx_push    <= 1'b0;
            tx_wdata   <= 8'd0;
            rx_pop     <= 1'b0;
            ctrl       <= CTRL_RST;
            baud_div   <= BAUD_RST;
        end else begin
            rdata_q    <= '0;
            rack_q     <= 1'b0;
            wack_q     <= 1'b0;
            raddrerr_q <= 1'b0;
            waddrerr_q <= 1'b0;
            tx_push    <= 1'b0;
            rx_pop     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.wr_en) begin
                        state      <= ST_WACK;
                        wack_q     <= 1'b1;
                        waddrerr_q <= w_err;
                        if (w_ctrl) begin
                            ctrl <= bus.wdata[7:0] & CTRL_MASK;
                        end
                        if (w_baud) begin
                            baud_div <= bus.wdata[15:0];
                        end
                        if (w_tx && !tx_full) begin
                            tx_push  <= 1'b1;
                            tx_wdata <= bus.wdata[7:0];
                        end
                    end else if (bus.rd_en) begin
                        state      <= ST_RACK;
                        rack_q     <= 1'b1;
                        raddrerr_q <= r_err;
                        rdata_q    <= r_data;
                        rx_pop     <= r_pop;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    rb_uart_int_ctrl u_int_ctrl (
        .clk        (apb_pclk),
        .resetn     (apb_presetn),
        .rx_empty   (rx_empty),
        .tx_empty   (tx_empty),
        .rx_ovr     (rx_ovr),
        .par_err    (par_err),
        .tx_ovf_set (tx_ovf_set),
        .int_en_we  (wr_go && w_int_en),
        .w1c_we     (wr_go && w_w1c),
        .wdata      (bus.wdata[INT_W-1:0]),
        .int_en     (int_en),
        .int_stat   (int_stat),
        .irq        (irq)
    );

endmodule

// File: tb/tb_rb_uart_regs.sv
// tb/tb_rb_uart_regs.sv - self-checking bench for rb_uart_regs
module tb_rb_uart_regs;

    logic        clk = 1'b0;
    logic        presetn = 1'b0;
    logic [7:0]  ctrl;
    logic [15:0] baud_div;
    logic        tx_push;
    logic [7:0]  tx_wdata;
    logic        tx_full = 1'b0;
    logic        tx_empty = 1'b1;
    logic        rx_empty = 1'b1;
    logic        rx_full = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_pop;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ovr = 1'b0;
    logic        par_err = 1'b0;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    logic [7:0] last_txd = 8'd0;

    rb_uart_regs_if bus ();

    rb_uart_regs dut (
        .apb_pclk    (clk),
        .apb_presetn (presetn),
        .bus         (bus),
        .ctrl        (ctrl),
        .baud_div    (baud_div),
        .tx_push     (tx_push),
        .tx_wdata    (tx_wdata),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .tx_busy     (tx_busy),
        .rx_pop      (rx_pop),
        .rx_data     (rx_data),
        .rx_ovr      (rx_ovr),
        .par_err     (par_err),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_push) begin
            push_cnt++;
            last_txd = tx_wdata;
        end
        if (rx_pop) begin
            pop_cnt++;
        end
    end

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; strobe held through the ack cycle, returns at the following negedge
    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input bit ovr,
                             output logic ack, output logic err);
        bus.waddr = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        if (ovr) rx_ovr = 1'b1;
        @(negedge clk);
        rx_ovr = 1'b0;
        ack = bus.wack;
        err = bus.waddrerr;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic ack,
                            output logic err, output logic ack2, output logic [31:0] d2);
        bus.raddr = a;
        bus.rd_en = 1'b1;
        @(negedge clk);
        d   = bus.rdata;
        ack = bus.rack;
        err = bus.raddrerr;
        @(negedge clk);
        ack2 = bus.rack;
        d2   = bus.rdata;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr_ok(input string nm, input logic [11:0] a, input logic [31:0] d, input bit ovr);
        logic ack, err;
        bus_write(a, d, ovr, ack, err);
        check({nm, "_wack"}, {31'd0, ack}, 32'd1);
        check({nm, "_werr"}, {31'd0, err}, 32'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d, d2;
        logic ack, err, ack2;
        bus_read(a, d, ack, err, ack2, d2);
        check({nm, "_rack"}, {31'd0, ack}, 32'd1);
        check({nm, "_rdata"}, d, exp);
    endtask

    initial begin
        logic [31:0] d, d2;
        logic ack, err, ack2;
        int push0, pop0;

        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.raddr = '0;
        bus.waddr = '0;
        bus.wdata = '0;

        vecs[0]  = '{0, 12'h000, 32'h0,        1'b0, 32'h0C};
        vecs[1]  = '{0, 12'h004, 32'h0,        1'b0, 32'd54};
        vecs[2]  = '{0, 12'h014, 32'h0,        1'b0, 32'h00};
        vecs[3]  = '{0, 12'h018, 32'h0,        1'b0, 32'h00};
        vecs[4]  = '{0, 12'h010, 32'h0,        1'b0, 32'h05};
        vecs[5]  = '{0, 12'h00C, 32'h0,        1'b0, 32'h00};
        vecs[6]  = '{0, 12'h008, 32'h0,        1'b1, 32'h00};
        vecs[7]  = '{0, 12'h01C, 32'h0,        1'b1, 32'h00};
        vecs[8]  = '{0, 12'h002, 32'h0,        1'b1, 32'h00};
        vecs[9]  = '{1, 12'h010, 32'hFF,       1'b1, 32'h00};
        vecs[10] = '{1, 12'h00C, 32'h55,       1'b1, 32'h00};
        vecs[11] = '{1, 12'h001, 32'h99,       1'b1, 32'h00};
        vecs[12] = '{0, 12'h000, 32'h0,        1'b0, 32'h0C};
        vecs[13] = '{1, 12'h000, 32'h12345633, 1'b0, 32'h00};
        vecs[14] = '{0, 12'h000, 32'h0,        1'b0, 32'h33};
        vecs[15] = '{1, 12'h004, 32'hABCD1234, 1'b0, 32'h00};
        vecs[16] = '{0, 12'h004, 32'h0,        1'b0, 32'h1234};
        vecs[17] = '{1, 12'h014, 32'hFFFFFFE5, 1'b0, 32'h00};
        vecs[18] = '{0, 12'h014, 32'h0,        1'b0, 32'h05};
        vecs[19] = '{1, 12'h014, 32'h0,        1'b0, 32'h00};
        vecs[20] = '{0, 12'h014, 32'h0,        1'b0, 32'h00};
        vecs[21] = '{0, 12'h800, 32'h0,        1'b1, 32'h00};

        repeat (3) @(negedge clk);
        presetn = 1'b1;
        @(negedge clk);

        check("rst_rack",  {31'd0, bus.rack}, 32'd0);
        check("rst_wack",  {31'd0, bus.wack}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_irq",   {31'd0, irq}, 32'd0);
        check("rst_ctrl",  {24'd0, ctrl}, 32'h0C);
        check("rst_baud",  {16'd0, baud_div}, 32'd54);

        // Table-driven decode / register / error vectors
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data, 1'b0, ack, err);
                check($sformatf("v%0d_wack", i), {31'd0, ack}, 32'd1);
                check($sformatf("v%0d_werr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            end else begin
                bus_read(vecs[i].addr, d, ack, err, ack2, d2);
                check($sformatf("v%0d_rack", i), {31'd0, ack}, 32'd1);
                check($sformatf("v%0d_rerr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
                check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rd);
                check($sformatf("v%0d_rack_end", i), {31'd0, ack2}, 32'd0);
                check($sformatf("v%0d_rdata_end", i), d2, 32'd0);
            end
        end
        @(negedge clk);
        check("tbl_push_cnt", push_cnt, 0);
        check("tbl_pop_cnt",  pop_cnt, 0);

        // TX push: strobe held two cycles gives exactly one push
        wr_ok("tx_push", 12'h008, 32'h1A5, 1'b0);
        repeat (3) @(negedge clk);
        check("tx_push_cnt", push_cnt, 1);
        check("tx_wdata", {24'd0, last_txd}, 32'hA5);

        // TX overflow -> tx_ovf status, irq via INT_EN, W1C drops irq
        tx_full = 1'b1;
        wr_ok("tx_ovf", 12'h008, 32'h77, 1'b0);
        @(negedge clk);
        check("tx_ovf_no_push", push_cnt, 1);
        tx_full = 1'b0;
        rd_chk("ovf_stat", 12'h018, 32'h08);
        check("ovf_irq_off", {31'd0, irq}, 32'd0);
        wr_ok("ovf_en", 12'h014, 32'h08, 1'b0);
        check("ovf_irq_on", {31'd0, irq}, 32'd1);
        wr_ok("ovf_w1c", 12'h018, 32'h08, 1'b0);
        check("ovf_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("ovf_stat_clr", 12'h018, 32'h00);
        wr_ok("ovf_en_off", 12'h014, 32'h00, 1'b0);

        // RX pop with data present, then empty
        rx_data  = 8'h3C;
        rx_empty = 1'b0;
        @(negedge clk);
        pop0 = pop_cnt;
        rd_chk("rx_data", 12'h00C, 32'h3C);
        rx_empty = 1'b1;
        @(negedge clk);
        check("rx_pop_one", pop_cnt - pop0, 1);
        rd_chk("rx_empty", 12'h00C, 32'h00);
        @(negedge clk);
        check("rx_pop_none", pop_cnt - pop0, 1);
        rd_chk("rx_avail_stat", 12'h018, 32'h01);
        wr_ok("rx_avail_w1c", 12'h018, 32'h1F, 1'b0);

        // rx_ovr pulse coinciding with W1C of the same bit keeps it set
        rx_ovr = 1'b1;
        @(negedge clk);
        rx_ovr = 1'b0;
        rd_chk("ovr_stat", 12'h018, 32'h04);
        wr_ok("ovr_w1c_race", 12'h018, 32'h04, 1'b1);
        rd_chk("ovr_stat_kept", 12'h018, 32'h04);
        wr_ok("ovr_w1c", 12'h018, 32'h04, 1'b0);
        rd_chk("ovr_stat_clr", 12'h018, 32'h00);

        // tx_empty rising edge and par_err pulse
        tx_empty = 1'b0;
        @(negedge clk);
        tx_empty = 1'b1;
        par_err  = 1'b1;
        @(negedge clk);
        par_err  = 1'b0;
        rd_chk("txe_par_stat", 12'h018, 32'h12);
        wr_ok("par_en", 12'h014, 32'h10, 1'b0);
        check("par_irq_on", {31'd0, irq}, 32'd1);

        // Reset asserted on the strobe cycle aborts the read
        push0 = push_cnt;
        pop0  = pop_cnt;
        rx_data    = 8'h77;
        rx_empty   = 1'b0;
        bus.raddr  = 12'h00C;
        bus.rd_en  = 1'b1;
        presetn    = 1'b0;
        @(negedge clk);
        check("abort_rack",  {31'd0, bus.rack}, 32'd0);
        check("abort_rdata", bus.rdata, 32'd0);
        check("abort_pop",   {31'd0, rx_pop}, 32'd0);
        check("abort_irq",   {31'd0, irq}, 32'd0);
        check("abort_ctrl",  {24'd0, ctrl}, 32'h0C);
        check("abort_baud",  {16'd0, baud_div}, 32'd54);
        bus.rd_en = 1'b0;
        rx_empty  = 1'b1;
        presetn   = 1'b1;
        @(negedge clk);
        check("abort_pop_cnt", pop_cnt - pop0, 0);
        check("abort_push_cnt", push_cnt - push0, 0);
        rd_chk("post_rst_ctrl", 12'h000, 32'h0C);
        rd_chk("post_rst_stat", 12'h018, 32'h00);
        rd_chk("post_rst_en",   12'h014, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
